// File: rtl/cpstr_wrr_sched.sv
// cpstr_wrr_sched: weighted round-robin grant of one byte stream at a time,
// with a per-stream burst quota and a switch pulse whenever the granted index changes.
module cpstr_wrr_sched #(
    parameter int NUM_STREAMS = 4,
    parameter int QW          = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_STREAMS-1:0]         i_req,
    input  logic [QW*NUM_STREAMS-1:0]      i_quota,
    input  logic                           i_xfer,
    output logic [NUM_STREAMS-1:0]         o_grant,
    output logic [$clog2(NUM_STREAMS)-1:0] o_grant_idx,
    output logic                           o_grant_valid,
    output logic                           o_switch,
    output logic [QW-1:0]                  o_rem
);
    localparam int IW = $clog2(NUM_STREAMS);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]             state;
    logic [IW-1:0]          g, ptr, last_idx, nxt, base, pick;
    logic                   last_vld, sw, found, release_now;
    logic [QW-1:0]          rem, pick_quota;
    logic [NUM_STREAMS-1:0] elig;

    // Release re-arbitrates in the same edge starting just past the released stream.
    always_comb begin
        for (int i = 0; i < NUM_STREAMS; i++)
            elig[i] = i_req[i] && i_quota[QW*i +: QW] != '0;
        nxt         = (g == IW'(NUM_STREAMS-1)) ? '0 : g + IW'(1);
        release_now = state == GRANT && (i_xfer ? rem == '0 : !i_req[g]);
        base        = release_now ? nxt : ptr;
        pick        = '0;
        found       = 1'b0;
        for (int k = NUM_STREAMS-1; k >= 0; k--) begin
            if (elig[(int'(base) + k) % NUM_STREAMS]) begin
                pick  = IW'((int'(base) + k) % NUM_STREAMS);
                found = 1'b1;
            end
        end
        pick_quota = i_quota[QW*pick +: QW];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            g        <= '0;
            ptr      <= '0;
            rem      <= '0;
            sw       <= 1'b0;
            last_idx <= '0;
            last_vld <= 1'b0;
        end else begin
            sw <= 1'b0;
            if (state == GRANT && i_xfer && rem != '0)
                rem <= rem - QW'(1);
            if (release_now)
                ptr <= nxt;
            if ((state == IDLE || release_now) && found) begin
                state    <= GRANT;
                g        <= pick;
                rem      <= pick_quota - QW'(1);
                sw       <= !last_vld || pick != last_idx;
                last_idx <= pick;
                last_vld <= 1'b1;
            end else if (release_now) begin
                state <= IDLE;
                g     <= '0;
                rem   <= '0;
            end
        end
    end

    assign o_grant       = (state == GRANT) ? NUM_STREAMS'(1) << g : '0;
    assign o_grant_idx   = g;
    assign o_grant_valid = state == GRANT;
    assign o_switch      = sw;
    assign o_rem         = rem;
endmodule

// File: tb/tb_cpstr_wrr_sched.sv
// tb_cpstr_wrr_sched: scoreboard bench; a burst-level reference model queues the
// expected outputs for each cycle and a monitor compares them against the DUT.
module tb_cpstr_wrr_sched;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] quota;
    logic        xfer;
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic        grant_valid, sw;
    logic [7:0]  rem;

    cpstr_wrr_sched #(.NUM_STREAMS(4), .QW(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_quota(quota), .i_xfer(xfer),
        .o_grant(grant), .o_grant_idx(grant_idx), .o_grant_valid(grant_valid),
        .o_switch(sw), .o_rem(rem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] idx;
        logic       vld;
        logic       sw;
        logic [7:0] rem;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    // Model state: owner=-1 when idle, left = bytes still allowed in the burst, last=-1 before any grant.
    int owner, left, ptr, last;

    function automatic int arb(input int p, input logic [3:0] r, input logic [31:0] qv);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j] && qv[8*j +: 8] != 8'd0) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        owner = -1; left = 0; ptr = 0; last = -1;
    endtask

    task automatic step(input logic [3:0] r, input logic [31:0] qv, input logic x);
        int   s;
        bit   sw_e;
        exp_t e;
        req = r; quota = qv; xfer = x;
        s = -2;
        sw_e = 0;
        if (owner < 0) s = arb(ptr, r, qv);
        else begin
            if (x) left--;
            if (left == 0 || (!x && !r[owner])) begin
                ptr = (owner + 1) % N;
                s = arb(ptr, r, qv);
                if (s < 0) owner = -1;
            end
        end
        if (s >= 0) begin
            sw_e  = (s != last);
            owner = s;
            left  = int'(qv[8*s +: 8]);
            last  = s;
        end
        e.grant = (owner < 0) ? 4'd0 : 4'(1 << owner);
        e.idx   = (owner < 0) ? 2'd0 : 2'(owner);
        e.vld   = owner >= 0;
        e.sw    = sw_e;
        e.rem   = (owner < 0) ? 8'd0 : 8'(left - 1);
        q.push_back(e);
        @(posedge clk); #2;
    endtask

    task automatic check_zero(input string name);
        nvec++;
        if (grant !== 4'd0 || grant_idx !== 2'd0 || grant_valid !== 1'b0 || sw !== 1'b0 || rem !== 8'd0) begin
            nerr++;
            $display("FAIL %s: got grant=%b idx=%0d vld=%b sw=%b rem=%0d, want all zero",
                     name, grant, grant_idx, grant_valid, sw, rem);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (q.size() != 0) begin
                e = q.pop_front();
                nvec++;
                if (grant !== e.grant || grant_idx !== e.idx || grant_valid !== e.vld ||
                    sw !== e.sw || rem !== e.rem) begin
                    nerr++;
                    $display("FAIL cycle %0d: got grant=%b idx=%0d vld=%b sw=%b rem=%0d, want grant=%b idx=%0d vld=%b sw=%b rem=%0d",
                             cyc, grant, grant_idx, grant_valid, sw, rem,
                             e.grant, e.idx, e.vld, e.sw, e.rem);
                end
            end
        end
    end

    initial begin
        logic [31:0] qv;
        int          w;
        rst_n = 1'b0; req = 4'b1111; quota = {8'd4, 8'd4, 8'd4, 8'd2}; xfer = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset_hold");
        rst_n = 1'b1;
        step(4'b1111, {8'd4, 8'd4, 8'd4, 8'd2}, 1'b0);
        repeat (24) step(4'b1111, {8'd4, 8'd4, 8'd4, 8'd2}, 1'b1);
        repeat (10) step(4'b0100, {8'd1, 8'd3, 8'd2, 8'd5}, 1'b1);
        repeat (12) step(4'b0011, {8'd2, 8'd2, 8'd0, 8'd3}, 1'b1);
        repeat (2)  step(4'b0000, {8'd2, 8'd2, 8'd10, 8'd3}, 1'b0);
        repeat (3)  step(4'b0010, {8'd2, 8'd2, 8'd10, 8'd3}, 1'b1);
        step(4'b0001, {8'd2, 8'd2, 8'd10, 8'd3}, 1'b0);
        repeat (3)  step(4'b0000, {8'd2, 8'd2, 8'd10, 8'd3}, 1'b0);
        qv = {8'd3, 8'd2, 8'd1, 8'd4};
        repeat (700) begin
            if ($urandom_range(0, 7) == 0)
                for (int i = 0; i < N; i++) qv[8*i +: 8] = 8'($urandom_range(0, 5));
            step(4'($urandom), qv, $urandom_range(0, 3) != 0);
        end
        qv = {8'd3, 8'd2, 8'd1, 8'd10};
        repeat (2) step(4'b0000, qv, 1'b0);
        step(4'b0001, qv, 1'b0);
        repeat (4) step(4'b0001, qv, 1'b1);
        w = 0;
        while (q.size() != 0 && w < 10) begin @(posedge clk); #2; w++; end
        nvec++;
        if (q.size() != 0 || rem !== 8'd5) begin
            nerr++;
            $display("FAIL pre_reset_rem: got rem=%0d pending=%0d, want rem=5 pending=0", rem, q.size());
        end
        #3 rst_n = 1'b0;
        #1 check_zero("async_reset");
        q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        model_reset();
        repeat (8) step(4'b0001, qv, 1'b1);
        w = 0;
        while (q.size() != 0 && w < 10) begin @(posedge clk); #2; w++; end
        if (q.size() != 0) begin
            nvec++; nerr++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
